pipe_mem_arbiter: RTL and testbench

Single-port memory arbiter/sequencer for the pipelined CPU. It shares one unified instruction/data RAM between the fetch stage (read-only) and the memory stage (load/store). Data accesses have priority, with a bounded anti-starvation rule for fetch. It drives stall outputs that freeze the pipeline while an access is outstanding.

---
 rtl/pipe_mem_arbiter_pkg.sv | 23 ++
 rtl/pipe_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_pipe_mem_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_mem_arbiter_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter.
//   arb_state_t : sequencer states (IDLE, WAIT, RESP)
//   owner_t     : which requester owns the access in flight
//   AW_DEF/DW_DEF : default address / data widths
//   CNT_W       : width of the latency and starve counters
package pipe_mem_arbiter_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/pipe_mem_arbiter.sv
// Single-port memory arbiter/sequencer shared by the fetch stage (read-only)
// and the memory stage (load/store). Data accesses win arbitration, but after
// STARVE_LIM consecutive data grants with fetch waiting, fetch is forced.
//
// Ports:
//   clock, reset          : rising-edge clock, async active-high reset
//   if_req/if_addr        : fetch request (level) and address
//   if_rdata/if_valid     : fetched word and its one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata : data request, store flag, address, data
//   dm_rdata/dm_valid     : load data and one-cycle completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : single-port RAM interface
//   stall_if/stall_mem    : pipeline freeze while a request is outstanding
module pipe_mem_arbiter
  import pipe_mem_arbiter_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_valid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_mem
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
    $error("pipe_mem_arbiter: MEM_LAT=%0d outside 1..15", MEM_LAT);
  end
  if (STARVE_LIM < 1 || STARVE_LIM > 15) begin : g_bad_starve_lim
    $error("pipe_mem_arbiter: STARVE_LIM=%0d outside 1..15", STARVE_LIM);
  end

  localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIM);

  arb_state_t       state;
  owner_t           owner;
  logic [CNT_W-1:0] lat_cnt;
  logic [CNT_W-1:0] starve_cnt;
  logic             grant_if;

  // Saturating increment of the starve counter.
  function automatic logic [CNT_W-1:0] starve_inc(input logic [CNT_W-1:0] cnt);
    return (cnt >= STARVE_MAX) ? cnt : cnt + 1'b1;
  endfunction

  // Fetch wins when data is idle, or when fetch has been starved long enough.
  assign grant_if  = if_req & (~dm_req | (starve_cnt == STARVE_MAX));

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = dm_req & ~dm_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_valid   <= 1'b0;
      dm_valid   <= 1'b0;
    end else begin
      // Strobes are single-cycle; only the state that raises them sets them.
      mem_en   <= 1'b0;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        // Arbitration: launch an access and arm the latency counter
        IDLE: begin
          if (grant_if) begin
            owner      <= OWN_IF;
            mem_addr   <= if_addr;
            mem_we     <= 1'b0;
            mem_en     <= 1'b1;
            lat_cnt    <= LAT_LOAD;
            starve_cnt <= '0;
            state      <= WAIT;
          end else if (dm_req) begin
            owner      <= OWN_DM;
            mem_addr   <= dm_addr;
            mem_we     <= dm_we;
            mem_wdata  <= dm_wdata;
            mem_en     <= 1'b1;
            lat_cnt    <= LAT_LOAD;
            starve_cnt <= if_req ? starve_inc(starve_cnt) : '0;
            state      <= WAIT;
          end
        end
        // Memory latency: capture read data on the final count
        WAIT: begin
          if (lat_cnt == '0) begin
            if (owner == OWN_IF) begin
              if_rdata <= mem_rdata;
              if_valid <= 1'b1;
            end else begin
              if (!mem_we) dm_rdata <= mem_rdata;
              dm_valid <= 1'b1;
            end
            state <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        // Response: the valid pulse is out; the requester's req is stale here
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed bench for pipe_mem_arbiter: a MEM_LAT=2 instance covers reset,
// fetch, store, load and starvation; a MEM_LAT=1 instance covers the short
// latency and back-to-back fetch spacing.
module tb_pipe_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  always #5 clock = ~clock;

  // MEM_LAT = 2 instance
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_valid, dm_valid, mem_en, mem_we, stall_if, stall_mem;

  // MEM_LAT = 1 instance
  logic        if_req1 = 1'b0, dm_req1 = 1'b0, dm_we1 = 1'b0;
  logic [31:0] if_addr1 = '0, dm_addr1 = '0, dm_wdata1 = '0;
  logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        if_valid1, dm_valid1, mem_en1, mem_we1, stall_if1, stall_mem1;

  pipe_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .STARVE_LIM(4)) u_dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  pipe_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_LIM(4)) u_dut1 (
    .clock(clock), .reset(reset),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_valid(if_valid1),
    .dm_req(dm_req1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
    .dm_rdata(dm_rdata1), .dm_valid(dm_valid1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .stall_if(stall_if1), .stall_mem(stall_mem1)
  );

  // RAM contents as seen by reads; unlisted addresses return a tagged pattern.
  function automatic logic [31:0] mem_lookup(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'h2002_0005;
      32'h0000_0084: return 32'h1234_5678;
      default:       return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // Memory models: data is valid only in the cycle MEM_LAT after mem_en,
  // junk at all other times.
  logic        m0_busy = 1'b0, m1_busy = 1'b0;
  logic [3:0]  m0_age = '0;
  logic [31:0] m0_addr = '0, m1_addr = '0;

  always @(posedge clock) begin
    if (mem_en) begin
      m0_busy <= 1'b1; m0_age <= 4'd1; m0_addr <= mem_addr;
    end else if (m0_busy) begin
      if (m0_age == 4'd2) m0_busy <= 1'b0;
      else                m0_age  <= m0_age + 4'd1;
    end
  end
  assign mem_rdata = m0_busy && (m0_age == 4'd2) ? mem_lookup(m0_addr) : 32'hDEAD_0BAD;

  always @(posedge clock) begin
    if (mem_en1) begin
      m1_busy <= 1'b1; m1_addr <= mem_addr1;
    end else begin
      m1_busy <= 1'b0;
    end
  end
  assign mem_rdata1 = m1_busy ? mem_lookup(m1_addr) : 32'hDEAD_0BAD;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk_vec(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  // Advance n cycles; land just after the falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    cyc(2);
    chk_vec("rst mem_en", mem_en, 0);
    chk_vec("rst mem_we", mem_we, 0);
    chk_vec("rst mem_addr", mem_addr, 0);
    chk_vec("rst mem_wdata", mem_wdata, 0);
    chk_vec("rst if_rdata", if_rdata, 0);
    chk_vec("rst dm_rdata", dm_rdata, 0);
    chk_vec("rst if_valid", if_valid, 0);
    chk_vec("rst dm_valid", dm_valid, 0);
    reset = 1'b0;

    // Reset during WAIT of a fetch to 0x40
    cyc(1); if_req = 1'b1; if_addr = 32'h40;
    cyc(1);
    chk_vec("rstmid mem_en pre", mem_en, 1);
    chk_vec("rstmid mem_addr pre", mem_addr, 32'h40);
    reset = 1'b1; if_req = 1'b0;
    #1;
    chk_vec("rstmid mem_en", mem_en, 0);
    chk_vec("rstmid mem_addr", mem_addr, 0);
    chk_vec("rstmid stall_if", stall_if, 0);
    cyc(1); reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cyc(1);
      chk_vec("rstmid if_valid", if_valid, 0);
      chk_vec("rstmid mem_en post", mem_en, 0);
    end
    chk_vec("rstmid if_rdata", if_rdata, 0);

    // Lone fetch at 0x10
    cyc(1); if_req = 1'b1; if_addr = 32'h10; #1;
    chk_vec("fetch stall_if c0", stall_if, 1);
    cyc(1);
    chk_vec("fetch mem_en c1", mem_en, 1);
    chk_vec("fetch mem_addr c1", mem_addr, 32'h10);
    chk_vec("fetch mem_we c1", mem_we, 0);
    cyc(1);
    chk_vec("fetch mem_en c2", mem_en, 0);
    chk_vec("fetch stall_if c2", stall_if, 1);
    cyc(1);
    chk_vec("fetch if_valid c3", if_valid, 0);
    chk_vec("fetch stall_if c3", stall_if, 1);
    cyc(1);
    chk_vec("fetch if_valid c4", if_valid, 1);
    chk_vec("fetch if_rdata c4", if_rdata, 32'h2002_0005);
    chk_vec("fetch stall_if c4", stall_if, 0);
    if_req = 1'b0;
    cyc(1);
    chk_vec("fetch if_valid c5", if_valid, 0);

    // Store to 0x80 with fetch of 0x20 also pending: data first
    cyc(1);
    if_req = 1'b1; if_addr = 32'h20;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'hDEAD_BEEF; #1;
    chk_vec("store stall_mem c0", stall_mem, 1);
    cyc(1);
    chk_vec("store mem_en c1", mem_en, 1);
    chk_vec("store mem_we c1", mem_we, 1);
    chk_vec("store mem_addr c1", mem_addr, 32'h80);
    chk_vec("store mem_wdata c1", mem_wdata, 32'hDEAD_BEEF);
    cyc(3);
    chk_vec("store dm_valid c4", dm_valid, 1);
    chk_vec("store if_valid c4", if_valid, 0);
    chk_vec("store dm_rdata c4", dm_rdata, 0);
    dm_req = 1'b0; dm_we = 1'b0;
    cyc(1);
    chk_vec("store dm_valid c5", dm_valid, 0);
    chk_vec("store mem_en c5", mem_en, 0);
    cyc(1);
    chk_vec("store fetch mem_en c6", mem_en, 1);
    chk_vec("store fetch mem_addr c6", mem_addr, 32'h20);
    chk_vec("store fetch mem_we c6", mem_we, 0);
    chk_vec("store fetch mem_wdata c6", mem_wdata, 32'hDEAD_BEEF);
    cyc(3);
    chk_vec("store fetch if_valid c9", if_valid, 1);
    chk_vec("store fetch if_rdata c9", if_rdata, 32'hA5A5_0020);
    if_req = 1'b0;

    // Load from 0x84
    cyc(1); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h84;
    cyc(1);
    chk_vec("load mem_en c1", mem_en, 1);
    chk_vec("load mem_we c1", mem_we, 0);
    chk_vec("load mem_addr c1", mem_addr, 32'h84);
    cyc(3);
    chk_vec("load dm_valid c4", dm_valid, 1);
    chk_vec("load dm_rdata c4", dm_rdata, 32'h1234_5678);
    chk_vec("load if_rdata c4", if_rdata, 32'hA5A5_0020);
    dm_req = 1'b0;
    cyc(1);
    chk_vec("load dm_valid c5", dm_valid, 0);

    // Starvation: 4 data grants, forced fetch, data resumes
    cyc(1);
    if_req = 1'b1; if_addr = 32'h10;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h84;
    for (int c = 1; c <= 30; c++) begin
      int k;
      k = c / 5;
      cyc(1);
      chk_vec("starve mem_en", mem_en, (c % 5 == 1) && (c <= 26));
      if ((c % 5 == 1) && (c <= 26))
        chk_vec("starve mem_addr", mem_addr, (k == 4) ? 32'h10 : 32'h84);
      if (c % 5 == 4) begin
        chk_vec("starve if_valid", if_valid, k == 4);
        chk_vec("starve dm_valid", dm_valid, k != 4);
      end
      if (c == 26) begin
        if_req = 1'b0; dm_req = 1'b0;
      end
    end
    chk_vec("starve if_rdata", if_rdata, 32'h2002_0005);

    // MEM_LAT = 1: back-to-back fetches
    cyc(1); if_req1 = 1'b1; if_addr1 = 32'h10;
    for (int c = 1; c <= 11; c++) begin
      cyc(1);
      chk_vec("lat1 mem_en", mem_en1, (c == 1) || (c == 5) || (c == 9));
      chk_vec("lat1 if_valid", if_valid1, (c == 3) || (c == 7) || (c == 11));
      if (c == 3) chk_vec("lat1 if_rdata", if_rdata1, 32'h2002_0005);
    end
    if_req1 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
